div_scheduler: RTL and testbench
================================

# div_scheduler

Round-robin scheduler that shares one 4-bit sequential divider (start/X/Y in, one-cycle valid pulse with quot/rem out, 5-cycle latency from sampled start) among NREQ requesters. It arbitrates, launches the divider, returns the tagged result to the winner, short-circuits divide-by-zero, and recovers from a missing divider response with a watchdog. It sits between the requesting blocks and the single divider instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 8, max WAIT cycles before abandoning a divide (≥6)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request level
- req_x  in  4*NREQ  dividends, requester i at [4i+3:4i]
- req_y  in  4*NREQ  divisors, same packing
- gnt  out  NREQ  one-hot, one-cycle accept pulse
- busy  out  1  high whenever state ≠ IDLE
- div_start  out  1  divider start pulse
- div_x, div_y  out  4 each  operands to divider, held for whole operation
- div_valid  in  1  divider result strobe
- div_quot, div_rem  in  4 each  divider result
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  clog2(NREQ)  index of requester served
- rsp_quot, rsp_rem  out  4 each  result
- rsp_dz  out  1  divide-by-zero flag
- rsp_err  out  1  watchdog timeout flag

## Operation
- States: IDLE, ISSUE, WAIT, RESP. gnt, div_start, busy, rsp_valid decoded from state register only; no input-to-output combinational path.
- IDLE: if any req bit set, winner = first set bit searching from (ptr+1) mod NREQ upward with wrap; capture id, x, y from winner's lanes; ptr ← winner; go ISSUE. No req: stay.
- ISSUE (1 cycle): gnt[id]=1. If captured y≠0: div_start=1, go WAIT. If y=0: div_start stays 0, load result quot=4'hF, rem=x, dz=1, go RESP.
- WAIT: watchdog counter increments each cycle from 0. On div_valid: latch div_quot/div_rem, dz=0, err=0, go RESP. If counter reaches TIMEOUT first: result quot=0, rem=0, err=1, go RESP. div_valid and timeout in same cycle: div_valid wins.
- RESP (1 cycle): rsp_valid=1 with rsp_id/quot/rem/dz/err; go IDLE.
- rsp_* data registers hold last values between strobes; only rsp_valid qualifies them.
- Requester contract: hold req and operands until gnt. Operands are captured in the arbitration cycle; dropping req in ISSUE does not cancel the grant. A requester must not re-raise req expecting service before its rsp_valid.
- div_valid outside WAIT is ignored.
- div_x/div_y driven from capture registers from ISSUE until next capture.

## Timing
- Reset (rst=0 at a posedge): state IDLE, ptr=NREQ-1 (requester 0 has first priority), all outputs 0, watchdog 0. Reset mid-operation abandons the operation with no response; divider is reset by the same rst.
- Normal divide, arbitration in cycle T: gnt and div_start at T+1; divider valid at T+6; rsp_valid at T+7; IDLE at T+8; next gnt earliest T+9. Throughput one divide per 8 cycles.
- Divide-by-zero: gnt at T+1, rsp_valid at T+2, IDLE at T+3.
- Timeout: WAIT entered T+2; with no div_valid, rsp_valid with err=1 at T+2+TIMEOUT+1.
- Exactly one gnt per rsp_valid; gnt never overlaps rsp_valid.

## Test plan
- Single op: req[0], x=13, y=3 in T -> gnt=0001 and div_start at T+1, div_x=13/div_y=3; rsp_valid at T+7, id=0, quot=4, rem=1, dz=0, err=0.
- Divide-by-zero: req[2], x=9, y=0 -> no div_start; rsp_valid at T+2, id=2, quot=F, rem=9, dz=1.
- Round robin: req=1111 held continuously, after reset -> grants in order 0,1,2,3,0, each 8 cycles apart, each rsp_id matches grant.
- Watchdog: divider stubbed with div_valid=0, req[1] x=7 y=2 -> rsp_valid at T+11 (TIMEOUT=8), err=1, quot=0, rem=0; next request served normally.
- Reset mid-op: rst=0 at T+4 of a divide -> next cycle all outputs 0, no rsp_valid; after release, req[3] is served first only if req[0..2] low (ptr reset to NREQ-1).
- Spurious/edge: div_valid pulsed in IDLE and RESP -> no response; req dropped during ISSUE -> response still delivered at T+7 with captured operands.

Source files
------------

// File: rtl/div_scheduler_if.sv
// Signal bundle between the divide scheduler, its requesters and the shared divider.
// master = scheduler side; slave = requesters plus divider side.
interface div_scheduler_if #(parameter int NREQ = 4) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_x;
  logic [4*NREQ-1:0] req_y;
  logic [NREQ-1:0]   gnt;
  logic              busy;

  logic              div_start;
  logic [3:0]        div_x;
  logic [3:0]        div_y;
  logic              div_valid;
  logic [3:0]        div_quot;
  logic [3:0]        div_rem;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_quot;
  logic [3:0]        rsp_rem;
  logic              rsp_dz;
  logic              rsp_err;

  modport master (
    input  req, req_x, req_y, div_valid, div_quot, div_rem,
    output gnt, busy, div_start, div_x, div_y,
           rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz, rsp_err
  );

  modport slave (
    output req, req_x, req_y, div_valid, div_quot, div_rem,
    input  gnt, busy, div_start, div_x, div_y,
           rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz, rsp_err
  );
endinterface

// File: rtl/div_scheduler.sv
// Round-robin sharing of one sequential divider: arbitrate, issue, wait (with watchdog), respond.
// Latency arb->rsp 7 cycles (2 for divide-by-zero); requesters hold req until their one-cycle gnt.
module div_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8
) (
  input logic            clk,
  input logic            rst,
  div_scheduler_if.master bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [3:0]      r_x;
  logic [3:0]      r_y;
  logic [WDW-1:0]  r_wdog;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic            r_div_start;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [3:0]      r_rsp_quot;
  logic [3:0]      r_rsp_rem;
  logic            r_rsp_dz;
  logic            r_rsp_err;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [3:0]      w_x;
  logic [3:0]      w_y;

  // First requester at or after ptr+1, wrapping.
  always_comb begin
    int             w_idx;
    logic [IDW-1:0] w_cand;
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_cand = IDW'(w_idx);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_x = bus.req_x[{w_win, 2'b00} +: 4];
  assign w_y = bus.req_y[{w_win, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_wdog      <= '0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_div_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_quot  <= '0;
      r_rsp_rem   <= '0;
      r_rsp_dz    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_id        <= w_win;
            r_ptr       <= w_win;
            r_x         <= w_x;
            r_y         <= w_y;
            r_gnt       <= NREQ'(1) << w_win;
            r_busy      <= 1'b1;
            r_div_start <= (w_y != 4'd0);
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_gnt       <= '0;
          r_div_start <= 1'b0;
          r_wdog      <= '0;
          if (r_y == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quot  <= 4'hF;
            r_rsp_rem   <= r_x;
            r_rsp_dz    <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the timeout cycle still wins.
          if (bus.div_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quot  <= bus.div_quot;
            r_rsp_rem   <= bus.div_rem;
            r_rsp_dz    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_state     <= RESP;
          end else if (r_wdog == WDW'(TIMEOUT)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_quot  <= 4'd0;
            r_rsp_rem   <= 4'd0;
            r_rsp_dz    <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_wdog      <= r_wdog + 1'b1;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = r_busy;
  assign bus.div_start = r_div_start;
  assign bus.div_x     = r_x;
  assign bus.div_y     = r_y;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_quot  = r_rsp_quot;
  assign bus.rsp_rem   = r_rsp_rem;
  assign bus.rsp_dz    = r_rsp_dz;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_div_scheduler.sv
// Randomized scoreboard bench for div_scheduler with a behavioural divider stub.
// Expected grants/responses come from a transaction-level timing and round-robin model.
module tb_div_scheduler;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  typedef struct {
    int         gcyc;
    int         rcyc;
    int         id;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;

  div_scheduler_if #(.NREQ(NREQ)) u_if ();

  div_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   mon_en  = 0;

  // divider stub control
  bit         div_en  = 1;
  bit         spur_en = 0;
  int         div_cnt = 0;
  logic [3:0] op_x;
  logic [3:0] op_y;

  // reference model state
  exp_t       gq[$];
  exp_t       rq[$];
  bit         pend[NREQ];
  bit         granted[NREQ];
  logic [3:0] px[NREQ];
  logic [3:0] py[NREQ];
  int         drop_at[NREQ];
  int         rel_cyc[NREQ];
  int         ptr;
  int         next_arb;
  int         last_arb;
  bit         rnd_en = 0;
  bit         rr_en  = 0;
  exp_t       mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider stub: result 5 cycles after a sampled start; optional spurious strobes.
  initial begin
    u_if.div_valid = 1'b0;
    u_if.div_quot  = 4'd0;
    u_if.div_rem   = 4'd0;
    forever begin
      @(negedge clk);
      u_if.div_valid = 1'b0;
      if (div_cnt > 0) begin
        div_cnt--;
        if (div_cnt == 0 && div_en) begin
          u_if.div_valid = 1'b1;
          u_if.div_quot  = (op_y == 4'd0) ? 4'hF : op_x / op_y;
          u_if.div_rem   = (op_y == 4'd0) ? op_x : op_x % op_y;
        end
      end else if (spur_en && div_en && !u_if.div_start && $urandom_range(3) == 0) begin
        u_if.div_valid = 1'b1;
        u_if.div_quot  = 4'($urandom);
        u_if.div_rem   = 4'($urandom);
      end
      if (u_if.div_start) begin
        div_cnt = 5;
        op_x    = u_if.div_x;
        op_y    = u_if.div_y;
      end
    end
  end

  // Monitor: compares DUT grants/responses against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (u_if.gnt != '0 || (gq.size() > 0 && gq[0].gcyc <= cyc)) begin
          if (gq.size() == 0) begin
            chk("unexpected_gnt", 32'(u_if.gnt), 32'd0);
          end else begin
            mon_e = gq.pop_front();
            chk("gnt_cycle", 32'(cyc), 32'(mon_e.gcyc));
            chk("gnt_vec", 32'(u_if.gnt), 32'd1 << mon_e.id);
            chk("gnt_busy", 32'(u_if.busy), 32'd1);
            chk("div_start", 32'(u_if.div_start), 32'(mon_e.start));
            if (mon_e.start) begin
              chk("div_x", 32'(u_if.div_x), 32'(mon_e.x));
              chk("div_y", 32'(u_if.div_y), 32'(mon_e.y));
            end
          end
        end else if (u_if.div_start) begin
          chk("stray_div_start", 32'(u_if.div_start), 32'd0);
        end
        if (u_if.rsp_valid || (rq.size() > 0 && rq[0].rcyc <= cyc)) begin
          if (rq.size() == 0) begin
            chk("unexpected_rsp", 32'(u_if.rsp_valid), 32'd0);
          end else begin
            mon_e = rq.pop_front();
            chk("rsp_valid", 32'(u_if.rsp_valid), 32'd1);
            chk("rsp_cycle", 32'(cyc), 32'(mon_e.rcyc));
            chk("rsp_id", 32'(u_if.rsp_id), 32'(mon_e.id));
            chk("rsp_quot", 32'(u_if.rsp_quot), 32'(mon_e.q));
            chk("rsp_rem", 32'(u_if.rsp_rem), 32'(mon_e.r));
            chk("rsp_dz", 32'(u_if.rsp_dz), 32'(mon_e.dz));
            chk("rsp_err", 32'(u_if.rsp_err), 32'(mon_e.err));
            chk("rsp_busy", 32'(u_if.busy), 32'd1);
          end
        end
      end
    end
  end

  task automatic post(input int i, input logic [3:0] x, input logic [3:0] y);
    pend[i] = 1'b1;
    px[i]   = x;
    py[i]   = y;
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      u_if.req[i]         = pend[i];
      u_if.req_x[4*i +: 4] = px[i];
      u_if.req_y[4*i +: 4] = py[i];
    end
  endtask

  // One cycle of stimulus plus the arbitration/timing model for that cycle.
  task automatic step();
    int   c;
    int   w;
    bit   any;
    exp_t e;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < NREQ; i++) begin
      if (granted[i] && drop_at[i] == c) begin
        granted[i] = 1'b0;
        pend[i]    = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && c > rel_cyc[i]) begin
        if (rr_en)
          post(i, 4'($urandom), 4'($urandom_range(15, 1)));
        else if (rnd_en && $urandom_range(3) == 0)
          post(i, 4'($urandom), ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom));
      end
    end
    drive_req();
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) any |= pend[i] && !granted[i];
    if (c >= next_arb && any) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (ptr + k) % NREQ;
        if (w < 0 && pend[idx] && !granted[idx]) w = idx;
      end
      e.gcyc  = c + 1;
      e.id    = w;
      e.x     = px[w];
      e.y     = py[w];
      e.start = (py[w] != 4'd0);
      if (py[w] == 4'd0) begin
        e.q = 4'hF; e.r = px[w]; e.dz = 1'b1; e.err = 1'b0;
        e.rcyc = c + 2;  next_arb = c + 3;
      end else if (div_en) begin
        e.q = px[w] / py[w]; e.r = px[w] % py[w]; e.dz = 1'b0; e.err = 1'b0;
        e.rcyc = c + 7;  next_arb = c + 8;
      end else begin
        e.q = 4'd0; e.r = 4'd0; e.dz = 1'b0; e.err = 1'b1;
        e.rcyc = c + 3 + TIMEOUT;  next_arb = c + 4 + TIMEOUT;
      end
      gq.push_back(e);
      rq.push_back(e);
      ptr        = w;
      last_arb   = c;
      granted[w] = 1'b1;
      drop_at[w] = c + 1;
      rel_cyc[w] = e.rcyc;
    end
  endtask

  task automatic chk_zero();
    chk("rst_gnt", 32'(u_if.gnt), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_div_start", 32'(u_if.div_start), 32'd0);
    chk("rst_div_x", 32'(u_if.div_x), 32'd0);
    chk("rst_div_y", 32'(u_if.div_y), 32'd0);
    chk("rst_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(u_if.rsp_id), 32'd0);
    chk("rst_rsp_quot", 32'(u_if.rsp_quot), 32'd0);
    chk("rst_rsp_rem", 32'(u_if.rsp_rem), 32'd0);
    chk("rst_rsp_dz", 32'(u_if.rsp_dz), 32'd0);
    chk("rst_rsp_err", 32'(u_if.rsp_err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; granted[i] = 1'b0; rel_cyc[i] = -1; drop_at[i] = -1;
    end
    drive_req();
    @(negedge clk);
    chk_zero();
    gq.delete();
    rq.delete();
    div_cnt  = 0;
    ptr      = NREQ - 1;
    next_arb = 0;
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    bit save_rnd;
    bit busy_model;
    save_rnd = rnd_en;
    rnd_en   = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      busy_model = 1'b0;
      for (int i = 0; i < NREQ; i++) busy_model |= pend[i];
      if (!busy_model && gq.size() == 0 && rq.size() == 0 && cyc >= next_arb) break;
    end
    chk("drain_empty", 32'(gq.size() + rq.size()), 32'd0);
    rnd_en = save_rnd;
  endtask

  initial begin
    rst        = 1'b0;
    u_if.req   = '0;
    u_if.req_x = '0;
    u_if.req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      px[i] = 4'd0; py[i] = 4'd0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    post(0, 4'd13, 4'd3);
    drain();
    post(2, 4'd9, 4'd0);
    drain();

    div_en = 1'b0;
    post(1, 4'd7, 4'd2);
    drain();
    div_en = 1'b1;
    post(1, 4'd7, 4'd2);
    drain();

    spur_en = 1'b1;
    post(0, 4'd15, 4'd4);
    drain();

    post(0, 4'd13, 4'd3);
    step();
    while (cyc < last_arb + 3) step();
    do_reset();
    post(3, 4'd11, 4'd2);
    drain();

    do_reset();
    rr_en = 1'b1;
    repeat (45) step();
    rr_en = 1'b0;
    drain();

    rnd_en = 1'b1;
    repeat (1500) step();
    rnd_en = 1'b0;
    drain();

    spur_en = 1'b0;
    div_en  = 1'b0;
    rnd_en  = 1'b1;
    repeat (200) step();
    rnd_en = 1'b0;
    drain();
    div_en = 1'b1;

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
